// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, 8-bit frames, MSB first) on the picorv32 native bus.
// DATA/STATUS/CTRL registers at word offsets 0/1/2; bus outputs are zero when not acknowledging.
module spi_master #(
  parameter logic [7:0] DEFAULT_DIV = 8'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_cs_n_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state, state_next;
  logic [7:0]  tx_shift, rx_shift, rx_data;
  logic [7:0]  div, div_cnt;
  logic [2:0]  bit_cnt;
  logic        done, cs, sck;
  logic        access, is_write, busy, start, div_zero;
  logic        rise, advance, finish;
  logic [1:0]  reg_sel;
  logic [31:0] rdata_next;
  logic        unused_ok;

  // Handshake: one ready pulse per access because a pending ready blocks re-acceptance.
  assign access   = enable && mem_valid && !mem_ready;
  assign is_write = |mem_wstrb;
  assign reg_sel  = mem_addr[3:2];
  assign busy     = (state != IDLE);
  assign start    = access && is_write && mem_wstrb[0] && (reg_sel == 2'd0) && !busy;
  assign div_zero = (div_cnt == 8'd0);

  assign spi_sck_o  = sck;
  assign spi_mosi_o = tx_shift[7];
  assign spi_cs_n_o = ~cs;

  assign unused_ok = ^{mem_instr, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16]};

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOW;
      LOW: begin
        if (div_zero) begin
          state_next = HIGH;
          rise       = 1'b1;
        end
      end
      HIGH: begin
        if (div_zero) begin
          if (bit_cnt == 3'd7) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = LOW;
            advance    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_next = 32'h0;
    if (!is_write) begin
      case (reg_sel)
        2'd0:    rdata_next = {24'h0, rx_data};
        2'd1:    rdata_next = {30'h0, done, busy};
        2'd2:    rdata_next = {16'h0, div, 7'h0, cs};
        default: rdata_next = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      tx_shift  <= 8'h0;
      rx_shift  <= 8'h0;
      rx_data   <= 8'h0;
      div       <= DEFAULT_DIV;
      div_cnt   <= 8'h0;
      bit_cnt   <= 3'd0;
      done      <= 1'b0;
      cs        <= 1'b0;
      sck       <= 1'b0;
    end else begin
      mem_ready <= access;
      mem_rdata <= access ? rdata_next : 32'h0;
      if (access && !is_write && reg_sel == 2'd0) done <= 1'b0;
      if (access && reg_sel == 2'd2) begin
        if (mem_wstrb[0]) cs  <= mem_wdata[0];
        if (mem_wstrb[1]) div <= mem_wdata[15:8];
      end
      // Reloads read the current DIV, so a CTRL write lands on the next half-period.
      if (start) begin
        tx_shift <= mem_wdata[7:0];
        bit_cnt  <= 3'd0;
        div_cnt  <= div;
      end else if (rise) begin
        sck      <= 1'b1;
        rx_shift <= {rx_shift[6:0], spi_miso_i};
        div_cnt  <= div;
      end else if (advance) begin
        sck      <= 1'b0;
        tx_shift <= {tx_shift[6:0], 1'b0};
        bit_cnt  <= bit_cnt + 3'd1;
        div_cnt  <= div;
      end else if (finish) begin
        sck      <= 1'b0;
        rx_data  <= rx_shift;
        done     <= 1'b1;  // after the read-clear above, so completion wins a tie
      end else if (busy) begin
        div_cnt  <= div_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: bus reads are scoreboarded through exp_q by a negedge monitor,
// SCK/MOSI/CS timing is measured cycle by cycle around each transfer.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_rdata;
  logic        spi_sck_o, spi_mosi_o, spi_miso_i, spi_cs_n_o;
  logic        loopback = 1'b0;
  logic        miso_val = 1'b0;

  // Each entry is {check_data, expected_rdata}; writes push with check_data=0.
  logic [32:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int ready_cnt = 0;
  int acc_cnt = 0;
  int rdata_idle_err = 0;

  assign spi_miso_i = loopback ? spi_mosi_o : miso_val;

  spi_master #(.DEFAULT_DIV(8'd4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
    .spi_cs_n_o(spi_cs_n_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[32]) check("rdata", mem_rdata, e[31:0]);
      end
    end else if (mem_rdata != 32'h0) begin
      rdata_idle_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                     input logic chk, input logic [31:0] exp);
    int n = 0;
    exp_q.push_back({chk, exp});
    acc_cnt++;
    enable = 1'b1; mem_valid = 1'b1; mem_addr = addr; mem_wstrb = wstrb; mem_wdata = wdata;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_ready && n < 6);
    check("bus_ack", {31'h0, mem_ready}, 32'd1);
    if (!mem_ready) begin
      void'(exp_q.pop_back());
      acc_cnt--;
    end
    enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp);
    bus({28'h0, idx, 2'b00}, 4'h0, 32'h0, 1'b1, exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] wstrb, input logic [31:0] wdata);
    bus({28'h0, idx, 2'b00}, wstrb, wdata, 1'b0, 32'h0);
  endtask

  // Follows a transfer from its start edge until the 8th SCK fall (= BUSY falling).
  task automatic observe(input string tag, input int exp_cycles, input logic [7:0] exp_mosi,
                         input logic exp_cs_n);
    int n = 0;
    int rises = 0;
    int falls = 0;
    logic prev;
    logic [7:0] bits = 8'h0;
    logic cs_ok = 1'b1;
    prev = spi_sck_o;
    while (falls < 8 && n < 4000) begin
      @(posedge clk); #1; n++;
      if (!prev && spi_sck_o) begin
        rises++;
        bits = {bits[6:0], spi_mosi_o};
      end
      if (prev && !spi_sck_o) falls++;
      if (spi_cs_n_o !== exp_cs_n) cs_ok = 1'b0;
      prev = spi_sck_o;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_sck_pulses"}, rises, 8);
    check({tag, "_mosi_bits"}, {24'h0, bits}, {24'h0, exp_mosi});
    check({tag, "_cs_steady"}, {31'h0, cs_ok}, 32'd1);
  endtask

  task automatic count_extra_pulses(input string tag, input int cycles);
    int rises = 0;
    logic prev;
    prev = spi_sck_o;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (!prev && spi_sck_o) rises++;
      prev = spi_sck_o;
    end
    check(tag, rises, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset for 3 cycles
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", {31'h0, spi_cs_n_o}, 32'd1);
    check("rst_sck", {31'h0, spi_sck_o}, 32'd0);
    check("rst_mosi", {31'h0, spi_mosi_o}, 32'd0);
    check("rst_ready", {31'h0, mem_ready}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0000_0400);

    // loopback 0xA5 at DIV=4: 16*5 = 80 cycles
    loopback = 1'b1;
    wr(2'd0, 4'h1, 32'h0000_00A5);
    observe("a5", 80, 8'hA5, 1'b1);
    rd(2'd1, 32'h2);
    rd(2'd0, 32'hA5);
    rd(2'd1, 32'h0);

    // CTRL lane masking: lane 0 only touches CS
    wr(2'd2, 4'h1, 32'hFFFF_FF01);
    rd(2'd2, 32'h0000_0401);
    check("cs_asserted", {31'h0, spi_cs_n_o}, 32'd0);
    wr(2'd2, 4'h2, 32'h0000_0301);
    rd(2'd2, 32'h0000_0301);

    // DIV=0, CS on, MISO high: 16 cycles, reads 0xFF
    loopback = 1'b0; miso_val = 1'b1;
    wr(2'd2, 4'h3, 32'h0000_0001);
    wr(2'd0, 4'h1, 32'h0000_003C);
    observe("div0", 16, 8'h3C, 1'b0);
    rd(2'd0, 32'hFF);
    wr(2'd2, 4'h3, 32'h0000_0400);
    check("cs_released", {31'h0, spi_cs_n_o}, 32'd1);

    // write while busy is acknowledged but ignored
    loopback = 1'b1;
    wr(2'd0, 4'h1, 32'h0000_0055);
    fork
      observe("busy55", 80, 8'h55, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        wr(2'd0, 4'h1, 32'h0000_0012);
      end
    join
    count_extra_pulses("busy_extra_pulses", 60);
    rd(2'd0, 32'h55);

    // register 3, STATUS writes, unselected accesses, idle cycles
    rd(2'd3, 32'h0);
    wr(2'd3, 4'hF, 32'hFFFF_FFFF);
    wr(2'd1, 4'hF, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0);
    enable = 1'b0; mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'h0;
    repeat (5) @(posedge clk);
    mem_addr = 32'h0; mem_wstrb = 4'h1; mem_wdata = 32'h0000_00AA;
    repeat (5) @(posedge clk);
    #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    count_extra_pulses("unselected_no_start", 20);
    rd(2'd1, 32'h0);

    // reset at cycle 30 of a DIV=4 transfer with CS asserted
    wr(2'd2, 4'h1, 32'h0000_0001);
    wr(2'd0, 4'h1, 32'h0000_00F0);
    repeat (29) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_sck", {31'h0, spi_sck_o}, 32'd0);
    check("midrst_cs_n", {31'h0, spi_cs_n_o}, 32'd1);
    check("midrst_mosi", {31'h0, spi_mosi_o}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd(2'd1, 32'h0);
    count_extra_pulses("midrst_no_sck", 20);
    rd(2'd1, 32'h0);
    wr(2'd0, 4'h1, 32'h0000_0081);
    observe("x81", 80, 8'h81, 1'b1);
    rd(2'd1, 32'h2);
    rd(2'd0, 32'h81);
    rd(2'd1, 32'h0);

    // back-to-back: the next write is accepted right after BUSY falls
    wr(2'd0, 4'h1, 32'h0000_00C3);
    observe("b2b_first", 80, 8'hC3, 1'b1);
    wr(2'd0, 4'h1, 32'h0000_003A);
    observe("b2b_second", 80, 8'h3A, 1'b1);
    rd(2'd0, 32'h3A);

    // ---------------- final report ----------------
    repeat (3) @(posedge clk);
    check("ready_pulses", ready_cnt, acc_cnt);
    check("rdata_zero_when_idle", rdata_idle_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
